// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, response record
// and the strobe-width helper used to size byte-enable buses.
package apb_pkg;

    localparam int MAX_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational command address decode: slave index, in-range flag and
// word-alignment flag for the APB requester.
module apb_addr_decode #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_LSB    = 12,
    parameter int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output logic                  idx_valid,
    output logic                  aligned
);

    localparam int AL_W = $clog2(DATA_WIDTH / 8);
    localparam int HI_W = ADDR_WIDTH - SLV_LSB;

    logic [HI_W-1:0] slot;
    logic            unused_addr;

    // The whole field above SLV_LSB must name an existing slave, so upper
    // address bits outside the index field also produce a decode error.
    assign slot      = addr[ADDR_WIDTH-1:SLV_LSB];
    assign idx       = slot[IDX_W-1:0];
    assign idx_valid = (slot < HI_W'(NUM_SLAVES));

    generate
        if (AL_W > 0) begin : g_align
            assign aligned = (addr[AL_W-1:0] == '0);
        end else begin : g_byte
            assign aligned = 1'b1;
        end
    endgenerate

    assign unused_addr = ^addr;

endmodule

// File: rtl/apb_requester.sv
// APB requester: accepts one command at a time, runs SETUP/ACCESS on the
// decoded slave and holds the response until the driver consumes it.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLV_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr
);

    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, dec_idx;
    logic                    dec_valid, dec_aligned;
    logic [CNT_W-1:0]        cnt_q;
    apb_rsp_t                rsp_q, rsp_d;
    logic                    sel_ready, sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    accept, finish;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_LSB    (SLV_LSB),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr      (cmd_addr),
        .idx       (dec_idx),
        .idx_valid (dec_valid),
        .aligned   (dec_aligned)
    );

    assign cmd_ready   = (state_q == IDLE);
    assign sel_ready   = pready[idx_q];
    assign sel_err     = pslverr[idx_q];
    assign sel_rdata   = prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (dec_valid && dec_aligned) begin
                        state_d = SETUP;
                    end else begin
                        state_d = RESP;
                        rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b0};
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready on the final counted cycle beats the timeout.
                if (sel_ready) begin
                    state_d       = RESP;
                    finish        = 1'b1;
                    rsp_d.err     = sel_err;
                    rsp_d.timeout = 1'b0;
                    rsp_d.rdata   = (!pwrite && !sel_err) ? MAX_DATA_WIDTH'(sel_rdata) : '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    finish  = 1'b1;
                    rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= {STRB_W{1'b0}};
            idx_q     <= '0;
            cnt_q     <= '0;
            rsp_q     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_q     <= rsp_d;
            rsp_valid <= (state_d == RESP);
            if (accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
                idx_q  <= dec_idx;
                if (state_d == SETUP) begin
                    psel <= NUM_SLAVES'(1) << dec_idx;
                end
            end
            if (state_q == SETUP) begin
                penable <= 1'b1;
                cnt_q   <= '0;
            end
            if (state_q == ACCESS && !finish) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (finish) begin
                psel    <= '0;
                penable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: normal read/write, decode errors,
// timeout boundary, slave error with response back-pressure, mid-transfer reset.
module tb_apb_requester;

    logic         pclk;
    logic         presetn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [31:0]  cmd_addr;
    logic [31:0]  cmd_wdata;
    logic [3:0]   cmd_strb;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         rsp_timeout;
    logic [3:0]   psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [127:0] prdata;
    logic [3:0]   pready;
    logic [3:0]   pslverr;

    int errors = 0;
    int checks = 0;
    int count;

    apb_requester #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .NUM_SLAVES     (4),
        .SLV_LSB        (12),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
    endtask

    task automatic consumeResponse(input string tag);
        rsp_ready = 1'b1;
        tick();
        checkOutput({tag, "_rsp_dropped"}, rsp_valid, 0);
        checkOutput({tag, "_ready_again"}, cmd_ready, 1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        presetn   = 1'b0;
        rsp_ready = 1'b0;
        pready    = '0;
        pslverr   = '0;
        prdata    = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h1111_0000};
        applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);

        // Reset state
        repeat (2) @(posedge pclk);
        #1;
        checkOutput("rst_psel", psel, 0);
        checkOutput("rst_penable", penable, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_paddr", paddr, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        presetn = 1'b1;
        tick();

        // Read slave1 with two wait states; other slaves' ready/error are noise
        pready  = 4'b1101;
        pslverr = 4'b1101;
        applyStimulus(1, 0, 32'h0000_1004, 32'h0, 4'hF);
        tick();
        checkOutput("rd1_psel", psel, 4'b0010);
        checkOutput("rd1_penable_setup", penable, 0);
        checkOutput("rd1_paddr", paddr, 32'h0000_1004);
        checkOutput("rd1_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        count = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (penable && psel == 4'b0010) count++;
        end
        checkOutput("rd1_en_cycles", count, 3);
        checkOutput("rd1_not_yet", rsp_valid, 0);
        pready[1] = 1'b1;
        pslverr   = 4'b0000;
        tick();
        checkOutput("rd1_rsp_valid", rsp_valid, 1);
        checkOutput("rd1_rdata", rsp_rdata, 32'hCAFE_F00D);
        checkOutput("rd1_err", rsp_err, 0);
        checkOutput("rd1_psel_off", psel, 0);
        checkOutput("rd1_penable_off", penable, 0);
        consumeResponse("rd1");

        // Zero-wait write to slave2
        pready = 4'b0100;
        applyStimulus(1, 1, 32'h0000_2008, 32'hDEAD_BEEF, 4'b0101);
        tick();
        cmd_valid = 1'b0;
        checkOutput("wr_psel", psel, 4'b0100);
        checkOutput("wr_pwrite", pwrite, 1);
        checkOutput("wr_pwdata", pwdata, 32'hDEAD_BEEF);
        checkOutput("wr_pstrb", pstrb, 4'b0101);
        tick();
        checkOutput("wr_penable", penable, 1);
        checkOutput("wr_rsp_early", rsp_valid, 0);
        tick();
        checkOutput("wr_rsp_valid", rsp_valid, 1);
        checkOutput("wr_rdata_zero", rsp_rdata, 0);
        checkOutput("wr_err", rsp_err, 0);
        consumeResponse("wr");
        checkOutput("wr_paddr_hold", paddr, 32'h0000_2008);

        // Misaligned read: no bus activity, decode error
        pready = 4'b1111;
        applyStimulus(1, 0, 32'h0000_0003, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        checkOutput("mis_psel", psel, 0);
        checkOutput("mis_rsp_valid", rsp_valid, 1);
        checkOutput("mis_err", rsp_err, 1);
        checkOutput("mis_timeout", rsp_timeout, 0);
        checkOutput("mis_pstrb_read", pstrb, 0);
        consumeResponse("mis");

        // Out-of-range slave
        applyStimulus(1, 0, 32'h0000_5000, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        checkOutput("oor_psel", psel, 0);
        checkOutput("oor_err", rsp_err, 1);
        checkOutput("oor_timeout", rsp_timeout, 0);
        tick();
        checkOutput("oor_psel_hold", psel, 0);
        consumeResponse("oor");

        // Timeout: slave0 never ready
        pready = 4'b1110;
        applyStimulus(1, 0, 32'h0000_0000, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        count = (penable && psel == 4'b0001) ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (penable && psel == 4'b0001) count++;
        end
        checkOutput("to_access_cycles", count, 16);
        checkOutput("to_not_yet", rsp_valid, 0);
        tick();
        checkOutput("to_psel_off", psel, 0);
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_err", rsp_err, 1);
        checkOutput("to_timeout", rsp_timeout, 1);
        checkOutput("to_rdata", rsp_rdata, 0);
        consumeResponse("to");

        // Ready on the 16th ACCESS cycle wins over the timeout
        applyStimulus(1, 0, 32'h0000_0000, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        checkOutput("late_not_yet", rsp_valid, 0);
        pready[0] = 1'b1;
        tick();
        checkOutput("late_rsp_valid", rsp_valid, 1);
        checkOutput("late_err", rsp_err, 0);
        checkOutput("late_timeout", rsp_timeout, 0);
        checkOutput("late_rdata", rsp_rdata, 32'h1111_0000);
        consumeResponse("late");

        // Slave3 error with response back-pressure and a competing command
        pready  = 4'b1000;
        pslverr = 4'b1000;
        applyStimulus(1, 0, 32'h0000_3000, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checkOutput("se_rsp_valid", rsp_valid, 1);
        applyStimulus(1, 1, 32'h0000_1000, 32'h1234_5678, 4'hF);
        count = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid && rsp_err && !rsp_timeout && rsp_rdata == 0 && !cmd_ready) count++;
        end
        checkOutput("se_stable_cycles", count, 5);
        checkOutput("se_paddr_hold", paddr, 32'h0000_3000);
        cmd_valid = 1'b0;
        pslverr   = 4'b0000;
        consumeResponse("se");

        // Reset during ACCESS drops the bus at once and loses the command
        pready = 4'b0000;
        applyStimulus(1, 0, 32'h0000_0000, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checkOutput("mr_in_access", penable, 1);
        #2;
        presetn = 1'b0;
        #1;
        checkOutput("mr_psel", psel, 0);
        checkOutput("mr_penable", penable, 0);
        checkOutput("mr_rsp_valid", rsp_valid, 0);
        tick();
        presetn = 1'b1;
        tick();
        checkOutput("mr_no_rsp", rsp_valid, 0);
        checkOutput("mr_cmd_ready", cmd_ready, 1);

        // Post-reset zero-wait read of slave0
        prdata[31:0] = 32'h0BAD_F00D;
        pready       = 4'b0001;
        applyStimulus(1, 0, 32'h0000_0000, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checkOutput("pr_rsp_valid", rsp_valid, 1);
        checkOutput("pr_rdata", rsp_rdata, 32'h0BAD_F00D);
        checkOutput("pr_err", rsp_err, 0);
        consumeResponse("pr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
Synthesizable parametrised APB requester that replaces hand-driven bus tasks with a command/response front end and a protocol-correct APB master.
- Accepts one command at a time on a valid/ready interface.
- Decodes the command to one of NUM_SLAVES peripherals and runs the SETUP/ACCESS sequence.
- Returns read data and an error/timeout status on a held response channel.
- Sits between a test or CPU-side driver and the shared APB fabric.

Parameters:
ADDR_WIDTH, 32, paddr/cmd_addr width
DATA_WIDTH, 32, prdata/pwdata width; must be 8, 16 or 32
NUM_SLAVES, 4, number of psel lines; must be ≥1
SLV_LSB, 12, lowest address bit of the slave index field
TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready before abort; must be ≥1

Ports:
pclk  in  1  APB clock
presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising pclk
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes (forced to 0 on reads)
rsp_valid  out  1  response held until rsp_ready
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  slave error, decode error, misalignment or timeout
rsp_timeout  out  1  error caused by timeout
psel  out  NUM_SLAVES  one-hot select
penable  out  1  access phase
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
pready  in  NUM_SLAVES  per-slave ready
pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
Clocking and reset:
- Single clock pclk. presetn is asynchronous, active-low.
- All outputs are registered except cmd_ready.
- Reset clears psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the timeout counter; state goes to IDLE.
- Reset asserted mid-transfer drops psel/penable immediately. The in-flight command is lost and produces no response.

FSM states: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state==IDLE). No command is accepted while a response is pending.
- IDLE, on accept: register paddr/pwrite/pwdata/pstrb and compute idx = cmd_addr[SLV_LSB +: max(1,$clog2(NUM_SLAVES))].
  - Misaligned address (low $clog2(DATA_WIDTH/8) bits ≠0) or idx ≥ NUM_SLAVES: go to RESP with rsp_err=1 and rsp_timeout=0. No psel is asserted.
  - Otherwise: set psel[idx]=1, penable=0, and go to SETUP.
- SETUP: next edge sets penable=1, clears the counter, and goes to ACCESS. This is always exactly one cycle.
- ACCESS, pready[idx]=1 at an edge: clear psel/penable and go to RESP with rsp_valid=1 and rsp_err=pslverr[idx]. rsp_rdata = prdata slice idx for a read with pslverr=0, else 0.
- ACCESS, pready[idx]=0: increment the counter.
  - If the counter reaches TIMEOUT_CYCLES-1 at an edge where pready is still 0: clear psel/penable and go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A pready arriving on that same edge wins; no timeout is reported.
- RESP: rsp_valid=1 held with stable data. On an edge with rsp_ready=1, rsp_valid→0 and state→IDLE.
- The next command can be accepted one cycle after the response handshake.

Latency and bus rules:
- Zero-wait-state latency: accept edge T0, SETUP after T0, ACCESS after T1, pready sampled at T2, rsp_valid high after T2.
- paddr/pwrite/pwdata/pstrb hold their last values between transfers; they change only on accept.
- penable is never 1 without psel.
- Only psel[idx] is ever asserted, and only one at a time.
- pready/pslverr of unselected slaves are ignored.

Decomposition:
- Package apb_pkg: state enum apb_state_e {IDLE,SETUP,ACCESS,RESP}; function strb_width(DATA_WIDTH); response struct {rdata, err, timeout}.
- One sub-module apb_addr_decode holds the combinational idx/valid/aligned decode. FSM, counter and datapath stay in apb_requester.

Test Plan:
- Read 0x0000_1004, slave1 pready after 2 wait cycles, prdata=0xCAFEF00D → psel=4'b0010, penable high 3 cycles, rsp_rdata=0xCAFEF00D, rsp_err=0.
- Write 0x0000_2008 data 0xDEADBEEF strb 4'b0101, slave2 zero-wait → pwdata/pstrb match, rsp_valid 3 edges after accept, rsp_rdata=0.
- Read 0x0000_0003 (misaligned) and 0x0000_5000 (idx 5 ≥4) → psel stays 0, rsp_err=1, rsp_timeout=0.
- Slave0 holds pready=0 → exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1; pready on cycle 16 instead → normal completion.
- Slave3 returns pslverr=1 on a read; rsp_ready held low 5 cycles → rsp_err=1, rsp_rdata=0, response stable, cmd_ready=0 until handshake.
- presetn low during ACCESS → psel/penable 0 immediately, no rsp_valid; post-reset read to slave0 completes normally.
